// File: rtl/dil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dil_pkg
//  Description : Shared Dilithium types and constants used by the pointwise
//                multiplier, its bus interface and the Barrett reducer.
//                Contents: coeff_t (24-bit coefficient), Q, N, BARRETT_M and
//                the IDLE/RUN state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dil_pkg;

  typedef logic [23:0] coeff_t;

  localparam int Q         = 8380417;   // Dilithium modulus
  localparam int N         = 256;       // coefficients per polynomial
  localparam int BARRETT_M = 33587228;  // floor(2^48 / Q)

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : dil_pkg
`default_nettype wire

// File: rtl/poly_pointwise_mul_if.sv
`default_nettype none
// ============================================================================
//  Module      : poly_pointwise_mul_if
//  Description : Streaming bus of the pointwise multiplier.
//                Input side : in_valid_i / in_ready_o / a_i / b_i
//                Output side: out_valid_o / out_ready_i / c_o / out_idx_o /
//                             last_o
//                The slave modport is the multiplier, the master modport is
//                whatever feeds it and drains it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface poly_pointwise_mul_if;
  import dil_pkg::*;

  logic       in_valid_i;
  logic       in_ready_o;
  coeff_t     a_i;
  coeff_t     b_i;
  logic       out_valid_o;
  logic       out_ready_i;
  coeff_t     c_o;
  logic [7:0] out_idx_o;
  logic       last_o;

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o, out_idx_o, last_o
  );

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o, out_idx_o, last_o
  );

endinterface : poly_pointwise_mul_if
`default_nettype wire

// File: rtl/poly_pointwise_mul_barrett.sv
`default_nettype none
// ============================================================================
//  Module      : barrett_reduce
//  Description : Two-stage Barrett reduction of a 48-bit product modulo Q.
//                S2 registers r = p - qhat*Q (0 <= r < 3Q), S3 registers the
//                fully reduced value after two conditional subtractions.
//                Ports: clk_i, rst_ni (async, active-low), i_s2_en, i_s3_en
//                (per-stage hold), i_p (48-bit product), o_c (p mod Q).
//  Revision    : 1.0 - initial release
// ============================================================================
module barrett_reduce
  import dil_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_s2_en,
  input  logic        i_s3_en,
  input  logic [47:0] i_p,
  output coeff_t      o_c
);

  localparam logic [24:0] c_q25 = 25'(Q);

  logic [25:0] w_qhat;
  logic [24:0] w_r;
  logic [24:0] r_r;
  logic [24:0] w_r1;
  coeff_t      w_c;
  coeff_t      r_c;

  // qhat underestimates p/Q by at most 2, so r lies in [0, 3Q) and fits in
  // 25 bits. Computing the subtraction modulo 2^25 therefore gives r exactly.
  assign w_qhat = 26'((74'(i_p) * 74'(BARRETT_M)) >> 48);
  assign w_r    = i_p[24:0] - 25'(w_qhat * 26'(Q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_r <= '0;
    end else if (i_s2_en) begin
      r_r <= w_r;
    end
  end

  always_comb begin
    w_r1 = (r_r >= c_q25) ? (r_r - c_q25) : r_r;
    w_c  = 24'((w_r1 >= c_q25) ? (w_r1 - c_q25) : w_r1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_c <= '0;
    end else if (i_s3_en) begin
      r_c <= w_c;
    end
  end

  assign o_c = r_c;

endmodule : barrett_reduce
`default_nettype wire

// File: rtl/poly_pointwise_mul.sv
`default_nettype none
// ============================================================================
//  Module      : poly_pointwise_mul
//  Description : NTT-domain pointwise multiplier, c[i] = a[i]*b[i] mod Q,
//                one coefficient per cycle, three register stages
//                (S1 product, S2 Barrett remainder, S3 reduced result).
//                Ports: clk_i, rst_ni (async, active-low), start_i (begins a
//                polynomial while idle), bus (slave side of the streaming
//                interface), busy_o (high while running), done_o (one-cycle
//                pulse after the last output handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_pointwise_mul
  import dil_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  poly_pointwise_mul_if.slave  bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [8:0] c_n9       = 9'(N);
  localparam logic [7:0] c_last_idx = 8'(N - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [8:0]  r_in_cnt;
  logic [7:0]  r_out_cnt;
  logic [47:0] r_p;
  logic        r_v1;
  logic        r_v2;
  logic        r_v3;
  logic        r_done;

  logic        w_busy;
  logic        w_in_ready;
  logic        w_pipe_en;
  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_final;
  logic        w_start;
  coeff_t      w_c;

  // A stalled output freezes every stage, so nothing is ever overwritten.
  assign w_pipe_en = !(r_v3 && !bus.out_ready_i);
  assign w_in_hs   = bus.in_valid_i && w_in_ready;
  assign w_out_hs  = r_v3 && bus.out_ready_i;
  assign w_final   = w_out_hs && (r_out_cnt == c_last_idx);
  assign w_start   = (r_state == IDLE) && start_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = RUN;
      RUN:     if (w_final) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state == RUN);
    w_in_ready = w_busy && (r_in_cnt < c_n9) && w_pipe_en;
  end

  // ----------------------------------------------------------- counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_start) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_hs)  r_in_cnt  <= r_in_cnt + 9'd1;
      if (w_out_hs) r_out_cnt <= r_out_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_final;
    end
  end

  // ----------------------------------------------- S1 and valid chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_p  <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_pipe_en) begin
      r_p  <= 48'(bus.a_i) * 48'(bus.b_i);
      r_v1 <= w_in_hs;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  barrett_reduce u_barrett (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_s2_en (w_pipe_en),
    .i_s3_en (w_pipe_en),
    .i_p     (r_p),
    .o_c     (w_c)
  );

  // ------------------------------------------------------------ outputs
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_v3;
  assign bus.c_o         = w_c;
  assign bus.out_idx_o   = r_out_cnt;
  assign bus.last_o      = r_v3 && (r_out_cnt == c_last_idx);
  assign busy_o          = w_busy;
  assign done_o          = r_done;

endmodule : poly_pointwise_mul
`default_nettype wire

// File: tb/tb_poly_pointwise_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_pointwise_mul
//  Description : Scoreboard bench for poly_pointwise_mul. The driver pushes
//                the expected coefficient/index on every accepted pair; an
//                independent monitor pops and compares on every output
//                handshake, and checks hold behaviour while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_pointwise_mul;
  import dil_pkg::*;

  typedef struct {
    logic [23:0] c;
    logic [7:0]  idx;
    int          acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  poly_pointwise_mul_if pif();

  poly_pointwise_mul dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bus     (pif.slave),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  int   total       = 0;
  int   bad         = 0;
  int   cyc         = 0;
  int   exp_idx     = 0;
  int   last_hs_cyc = -10;
  bit   rnd_ready   = 1'b0;
  bit   chk_lat     = 1'b0;
  exp_t sb[$];

  logic        pv = 1'b0;
  logic [23:0] pc;
  logic [7:0]  pi;
  logic        pl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [23:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return 24'(p % 64'(Q));
  endfunction

  // Output-ready driver: always ready, or a fair coin each cycle.
  initial begin
    pif.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pif.out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv)
          check("stall_hold", {pif.out_valid_o, pif.c_o, pif.out_idx_o, pif.last_o},
                {1'b1, pc, pi, pl});
        pv = 1'b0;
        if (pif.out_valid_o && !pif.out_ready_i) begin
          check("stall_in_ready", pif.in_ready_o, 0);
          pv = 1'b1;
          pc = pif.c_o;
          pi = pif.out_idx_o;
          pl = pif.last_o;
        end
        if (pif.out_valid_o && pif.out_ready_i) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("c", pif.c_o, e.c);
            check("idx", pif.out_idx_o, e.idx);
            check("last", pif.last_o, (e.idx == 8'd255));
            if (chk_lat) check("latency", cyc, e.acc + 3);
            if (e.idx == 8'd255) last_hs_cyc = cyc;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pair is taken.
  task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    bit acc = 1'b0;
    int t   = 0;
    exp_t e;
    pif.a_i        = a;
    pif.b_i        = b;
    pif.in_valid_i = 1'b1;
    while (!acc && t < 3000) begin
      @(negedge clk);
      if (pif.in_ready_o) begin
        acc   = 1'b1;
        e.c   = c;
        e.idx = 8'(exp_idx);
        e.acc = cyc;
        sb.push_back(e);
        exp_idx++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    pif.in_valid_i = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic gap();
    if (rnd_ready) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    exp_idx = 0;
  endtask

  // Returns at the negedge one cycle after the done pulse.
  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 3000);
    check("done_seen", done, 1);
    check("done_timing", cyc, last_hs_cyc + 1);
    check("busy_with_done", busy, 0);
    check("sb_empty_at_done", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic send_random(input int count);
    logic [23:0] a;
    logic [23:0] b;
    for (int i = 0; i < count; i++) begin
      a = 24'($urandom_range(0, Q - 1));
      b = 24'($urandom_range(0, Q - 1));
      gap();
      send(a, b, ref_mul(a, b));
    end
  endtask

  // Main sequence.
  initial begin
    pif.in_valid_i = 1'b0;
    pif.a_i        = '0;
    pif.b_i        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, pif.in_ready_o, pif.out_valid_o, pif.c_o,
                            pif.out_idx_o, pif.last_o}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Run 1: directed products, start during RUN, then fill the polynomial.
    rnd_ready = 1'b0;
    chk_lat   = 1'b1;
    start_run();
    check("busy_after_start", busy, 1);
    send(24'd2, 24'd3, 24'd6);
    send(24'd0, 24'd8380416, 24'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_ignored_start", busy, 1);
    send(24'd8380416, 24'd8380416, 24'd1);
    send(24'd8380416, 24'd2, 24'd8380415);
    send(24'd8380417, 24'd5, 24'd0);
    send(24'd16777215, 24'd16777215, 24'd163817);
    send_random(250);
    wait_done();

    // Run 2: started the cycle after done, random backpressure and gaps.
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    exp_idx = 0;
    check("busy_restart_after_done", busy, 1);
    rnd_ready = 1'b1;
    chk_lat   = 1'b0;
    send_random(256);
    wait_done();

    // Run 3: reset in the middle of a polynomial.
    @(posedge clk);
    #1;
    start_run();
    send_random(100);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, pif.in_ready_o, pif.out_valid_o, pif.c_o,
                                  pif.out_idx_o, pif.last_o}, 0);
    sb.delete();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    start_run();
    send(24'd2, 24'd3, 24'd6);
    send(24'd8380416, 24'd2, 24'd8380415);
    send(24'd16777215, 24'd16777215, 24'd163817);
    send(24'd8380417, 24'd5, 24'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_poly_pointwise_mul
`default_nettype wire
